mem_seq_master: RTL

- Initiator for the team's single-port synchronous RAM interface (adr / dat_w / we / dat_r, registered read address).
- Fills the whole RAM with a seeded pattern, or reads every word back and checks it against that pattern.
- Reports error count and first failing address.
- Sits between the control/CSR logic and a RAM instance; used for power-on init and memory self-test.

---
 rtl/mem_seq_master_if.sv | 14 +
 rtl/mem_seq_master.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_seq_master_if.sv
// Single-port synchronous RAM bus: address, write data, write enable, read data.
// Read data follows the address by one clock because the RAM registers the address.
interface mem_seq_master_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic          we;
  logic [DW-1:0] dat_r;

  modport master (output adr, output dat_w, output we, input dat_r);
  modport slave  (input adr, input dat_w, input we, output dat_r);
endinterface

// File: rtl/mem_seq_master.sv
// RAM fill / self-check sequencer: writes seed+address to every word, or reads
// every word back and reports mismatch count and first failing address.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; results held
// S_FILL  | one write per cycle, addresses 0..2^AW-1
// S_READ  | one read per cycle; compares data of the previous address
// S_DRAIN | compares read data of the last address
// S_DONE  | one-cycle done pulse
module mem_seq_master #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   err_count,
  output logic          err_flag,
  output logic [AW-1:0] first_err_adr,
  mem_seq_master_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

  state_t        state, state_nxt;
  logic [AW:0]   cnt;
  logic [DW-1:0] seed_q;
  logic [AW-1:0] cmp_adr;
  logic [DW-1:0] exp_wr;
  logic [DW-1:0] exp_rd;
  logic          accept;
  logic          cnt_inc;
  logic          cmp_en;
  logic          mismatch;

  // Read data always belongs to the address issued one cycle earlier; in
  // DRAIN the low bits of cnt are zero, so this wraps to the last address.
  assign cmp_adr  = cnt[AW-1:0] - AW'(1);
  assign exp_wr   = seed_q + DW'(cnt[AW-1:0]);
  assign exp_rd   = seed_q + DW'(cmp_adr);
  assign mismatch = cmp_en && (mem.dat_r != exp_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem.we    = 1'b0;
    mem.adr   = '0;
    mem.dat_w = '0;
    accept    = 1'b0;
    cnt_inc   = 1'b0;
    cmp_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = mode ? S_READ : S_FILL;
        end
      end
      S_FILL: begin
        busy      = 1'b1;
        mem.we    = 1'b1;
        mem.adr   = cnt[AW-1:0];
        mem.dat_w = exp_wr;
        cnt_inc   = 1'b1;
        if (cnt == LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_READ: begin
        busy    = 1'b1;
        mem.adr = cnt[AW-1:0];
        cnt_inc = 1'b1;
        cmp_en  = (cnt != '0);
        if (cnt == LAST) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        cmp_en    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      seed_q        <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_adr <= '0;
    end else if (accept) begin
      cnt           <= '0;
      seed_q        <= seed;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_adr <= '0;
    end else begin
      if (cnt_inc) begin
        cnt <= cnt + (AW+1)'(1);
      end
      if (mismatch) begin
        err_count <= err_count + (AW+1)'(1);
        err_flag  <= 1'b1;
        if (err_count == '0) begin
          first_err_adr <= cmp_adr;
        end
      end
    end
  end

endmodule
